instr_encode_loader: RTL and testbench
======================================

// Module: instr_encode_loader
// PURPOSE
//  Encoder/writer counterpart of the single-cycle controller's decode path: accepts abstract operation requests
//  (op + register/immediate fields), encodes each into a MIPS32 instruction word, buffers it, and writes it
//  sequentially into instruction memory. Used by test harnesses and the boot path to build programs that the
//  fetch unit and controller then execute.
// PARAMETERS
//  BASE_ADDR   32'h0  byte address of first instruction word written
//  DEPTH       4      encoded-word FIFO depth (power of 2, >=2)
//  MAX_WORDS   256    words allowed per program; further requests refused
//  PAD_COUNT   2      NOP words appended after last request (only with PAD_NOP_EN)
// PORTS
//  Clk         in   1   clock, rising edge
//  Reset       in   1   asynchronous, active-low reset
//  Start       in   1   pulse in DONE: re-arm; address back to BASE_ADDR, counters cleared
//  ReqValid    in   1   request valid
//  ReqReady    out  1   request accepted when ReqValid & ReqReady at rising edge
//  ReqOp       in   6   operation code, OP_* in mips_isa_defs.vh (0..31 legal)
//  ReqLast     in   1   marks final request of program
//  ReqRs/ReqRt/ReqRd in 5  register fields
//  ReqShamt    in   5   shift amount
//  ReqImm      in   16  immediate / branch offset
//  ReqTarget   in   26  jump target
//  MemWrEn     out  1   instruction-memory write strobe
//  MemReady    in   1   memory accepts write this cycle
//  MemAddr     out  32  byte address of current write
//  MemWData    out  32  encoded instruction word
//  WordCount   out  16  words written this program
//  Done        out  1   level, high in DONE
//  Error       out  1   sticky: illegal ReqOp seen or MAX_WORDS exceeded
// BEHAVIOUR
//  Reset: ReqReady=0, MemWrEn=0, MemAddr=BASE_ADDR, MemWData=0, WordCount=0, Done=0, Error=0, FIFO empty, state LOAD.
//  States: LOAD -> (last accepted & FIFO drained) -> PAD (PAD_NOP_EN) or DONE; PAD -> (PAD_COUNT writes) -> DONE;
//    DONE -> (Start) -> LOAD. Start outside DONE ignored.
//  ReqReady = LOAD & !fifo_full & !last_seen & (accepted < MAX_WORDS); registered-state only, no comb path from MemReady.
//  Encoding (combinational, pushed on accept): R-type op=0 {rs,rt,rd,shamt,funct}: ADD 32, ADDU 33, SUB 34, AND 36,
//    OR 37, XOR 38, NOR 39, SLT 42, SLL 0, SLLV 4, JR 8, MOVZ 10; ROTR funct 2 with rs field forced 1;
//    ROTRV funct 6 with shamt field forced 1. SPECIAL2 op=28: CLZ 32, CLO 33. I-type {op,rs,rt,imm}: ADDI 8, ADDIU 9,
//    SLTI 10, ANDI 12, ORI 13, XORI 14, BEQ 4, BNE 5, BGTZ 7 (rt=0), LW 35, SW 43; REGIMM op=1: BLTZ rt=0, BGEZ rt=1.
//    J 2 / JAL 3 {op,target}. OP_NOP -> 32'h0. Unused fields zeroed.
//  Illegal ReqOp (>=32): request accepted, nothing pushed, Error set; ReqLast still honoured.
//  Latency: accept at edge N -> MemWrEn high from cycle N+1. MemWrEn = FIFO non-empty (or PAD active); MemWData = head.
//  Write completes on MemWrEn & MemReady: pop, MemAddr += 4 (32-bit wrap), WordCount += 1 (saturates 16'hFFFF).
//  MemReady low: MemWrEn/MemAddr/MemWData held stable. Push and pop same cycle: occupancy unchanged.
//  ReqValid while accepted==MAX_WORDS: ReqReady low, Error set; program ends only via ReqLast already seen.
//  Reset mid-program: immediate return to reset values; partial program abandoned, no further writes.
// CONFIGURATION
//  PAD_NOP_EN defined: after drain, PAD writes PAD_COUNT words of 32'h0 at continuing addresses, counted in WordCount.
//  PAD_NOP_EN undefined: LOAD -> DONE directly after drain; PAD state and PAD_COUNT absent.
// STRUCTURE
//  mips_isa_defs.vh: OP_* request enum, opcode/funct/REGIMM-rt constants, field widths; shared with controller.
//  Sub-module instr_word_fifo (sync FIFO, DEPTH x 32, full/empty/count); encoder and FSM inline.
// TESTING
//  ADD rs=1 rt=2 rd=3, MemReady=1 -> MemWData=32'h00221820 @MemAddr=BASE_ADDR, one cycle after accept.
//  ADDI rt=5 rs=0 imm=16'hFFFF, then LW rt=8 rs=29 imm=4 -> 32'h2005FFFF @+0, 32'h8FA80004 @+4.
//  ROTR rd=4 rt=2 shamt=3; JAL target=26'h10 (ReqLast) -> 32'h002220C2, 32'h0C000010; Done high after drain.
//  MemReady held low 6 cycles with 5 requests offered -> 4 accepted, ReqReady low, outputs stable, none lost.
//  ReqOp=40 with ReqLast -> no write, Error=1, Done=1; Start -> MemAddr=BASE_ADDR, WordCount=0, Error held.
//  PAD_NOP_EN, PAD_COUNT=2: one ORI then last -> three writes, last two 32'h0, WordCount=3; Reset mid-write -> MemWrEn=0.

Source files
------------

// File: rtl/instr_encode_loader_pkg.sv
// Shared MIPS32 request ops, opcode/funct constants and word builders.
// Loader FSM states; PAD exists only with PAD_NOP_EN.
package instr_encode_loader_pkg;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0, OP_ADD, OP_ADDU, OP_SUB,
        OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLL, OP_SLLV, OP_JR,
        OP_MOVZ, OP_ROTR, OP_ROTRV, OP_CLZ,
        OP_CLO, OP_ADDI, OP_ADDIU, OP_SLTI,
        OP_ANDI, OP_ORI, OP_XORI, OP_BEQ,
        OP_BNE, OP_BGTZ, OP_LW, OP_SW,
        OP_BLTZ, OP_BGEZ, OP_J, OP_JAL
    } req_op_e;

    localparam logic [5:0] OPC_SPECIAL  = 6'd0;
    localparam logic [5:0] OPC_REGIMM   = 6'd1;
    localparam logic [5:0] OPC_J        = 6'd2;
    localparam logic [5:0] OPC_JAL      = 6'd3;
    localparam logic [5:0] OPC_BEQ      = 6'd4;
    localparam logic [5:0] OPC_BNE      = 6'd5;
    localparam logic [5:0] OPC_BGTZ     = 6'd7;
    localparam logic [5:0] OPC_ADDI     = 6'd8;
    localparam logic [5:0] OPC_ADDIU    = 6'd9;
    localparam logic [5:0] OPC_SLTI     = 6'd10;
    localparam logic [5:0] OPC_ANDI     = 6'd12;
    localparam logic [5:0] OPC_ORI      = 6'd13;
    localparam logic [5:0] OPC_XORI     = 6'd14;
    localparam logic [5:0] OPC_SPECIAL2 = 6'd28;
    localparam logic [5:0] OPC_LW       = 6'd35;
    localparam logic [5:0] OPC_SW       = 6'd43;

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_ROTR  = 6'd2;
    localparam logic [5:0] FN_SLLV  = 6'd4;
    localparam logic [5:0] FN_ROTRV = 6'd6;
    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_MOVZ  = 6'd10;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_CLZ   = 6'd32;
    localparam logic [5:0] FN_CLO   = 6'd33;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [1:0] {
        ST_LOAD,
`ifdef PAD_NOP_EN
        ST_PAD,
`endif
        ST_DONE
    } state_e;

    function automatic logic [31:0] rword(
        input logic [5:0] op, input logic [4:0] rs,
        input logic [4:0] rt, input logic [4:0] rd,
        input logic [4:0] sh, input logic [5:0] fn
    );
        return {op, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] iword(
        input logic [5:0] op, input logic [4:0] rs,
        input logic [4:0] rt, input logic [15:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Synchronous DEPTH x WIDTH FIFO; head word visible on rdata.
// Caller never pushes when full nor pops when empty.
module instr_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes op requests into MIPS32 words and streams them to instruction memory.
// Optional PAD_NOP_EN appends PAD_COUNT NOP words after the last request.
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 4,
    parameter int          MAX_WORDS = 256
`ifdef PAD_NOP_EN
    ,
    parameter int          PAD_COUNT = 2
`endif
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [5:0]  ReqOp,
    input  logic        ReqLast,
    input  logic [4:0]  ReqRs,
    input  logic [4:0]  ReqRt,
    input  logic [4:0]  ReqRd,
    input  logic [4:0]  ReqShamt,
    input  logic [15:0] ReqImm,
    input  logic [25:0] ReqTarget,
    output logic        MemWrEn,
    input  logic        MemReady,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [15:0] WordCount,
    output logic        Done,
    output logic        Error
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state;
    logic          last_seen;
    logic [31:0]   accepted;
    logic          ready_q;
    logic [31:0]   enc_word;
    logic          enc_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head;
    logic          accept;
    logic          push;
    logic          pop;
    logic          wr_fire;
    logic          pad_act;
    logic [CW-1:0] cnt_nxt;
    logic          last_nxt;
    logic [31:0]   acc_nxt;
    logic          ready_d;
`ifdef PAD_NOP_EN
    logic [31:0]   pad_cnt;
`endif

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        unique case (ReqOp)
            OP_NOP:   enc_word = '0;
            OP_ADD:   enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_ADD);
            OP_ADDU:  enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_ADDU);
            OP_SUB:   enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_SUB);
            OP_AND:   enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_AND);
            OP_OR:    enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_OR);
            OP_XOR:   enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_XOR);
            OP_NOR:   enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_NOR);
            OP_SLT:   enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_SLT);
            OP_SLL:   enc_word = rword(OPC_SPECIAL, 5'd0, ReqRt, ReqRd, ReqShamt, FN_SLL);
            OP_SLLV:  enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_SLLV);
            OP_JR:    enc_word = rword(OPC_SPECIAL, ReqRs, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_MOVZ:  enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd0, FN_MOVZ);
            // rotates reuse the shift functs, told apart by rs/shamt bit 0
            OP_ROTR:  enc_word = rword(OPC_SPECIAL, 5'd1, ReqRt, ReqRd, ReqShamt, FN_ROTR);
            OP_ROTRV: enc_word = rword(OPC_SPECIAL, ReqRs, ReqRt, ReqRd, 5'd1, FN_ROTRV);
            OP_CLZ:   enc_word = rword(OPC_SPECIAL2, ReqRs, ReqRt, ReqRd, 5'd0, FN_CLZ);
            OP_CLO:   enc_word = rword(OPC_SPECIAL2, ReqRs, ReqRt, ReqRd, 5'd0, FN_CLO);
            OP_ADDI:  enc_word = iword(OPC_ADDI, ReqRs, ReqRt, ReqImm);
            OP_ADDIU: enc_word = iword(OPC_ADDIU, ReqRs, ReqRt, ReqImm);
            OP_SLTI:  enc_word = iword(OPC_SLTI, ReqRs, ReqRt, ReqImm);
            OP_ANDI:  enc_word = iword(OPC_ANDI, ReqRs, ReqRt, ReqImm);
            OP_ORI:   enc_word = iword(OPC_ORI, ReqRs, ReqRt, ReqImm);
            OP_XORI:  enc_word = iword(OPC_XORI, ReqRs, ReqRt, ReqImm);
            OP_BEQ:   enc_word = iword(OPC_BEQ, ReqRs, ReqRt, ReqImm);
            OP_BNE:   enc_word = iword(OPC_BNE, ReqRs, ReqRt, ReqImm);
            OP_BGTZ:  enc_word = iword(OPC_BGTZ, ReqRs, 5'd0, ReqImm);
            OP_LW:    enc_word = iword(OPC_LW, ReqRs, ReqRt, ReqImm);
            OP_SW:    enc_word = iword(OPC_SW, ReqRs, ReqRt, ReqImm);
            OP_BLTZ:  enc_word = iword(OPC_REGIMM, ReqRs, RT_BLTZ, ReqImm);
            OP_BGEZ:  enc_word = iword(OPC_REGIMM, ReqRs, RT_BGEZ, ReqImm);
            OP_J:     enc_word = {OPC_J, ReqTarget};
            OP_JAL:   enc_word = {OPC_JAL, ReqTarget};
            default:  enc_ok = 1'b0;
        endcase
    end

    instr_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef PAD_NOP_EN
    assign pad_act = (state == ST_PAD);
`else
    assign pad_act = 1'b0;
`endif

    assign ReqReady = ready_q;
    assign accept   = ReqValid & ready_q;
    assign push     = accept & enc_ok & ~fifo_full;
    assign MemWrEn  = ~fifo_empty | pad_act;
    assign MemWData = fifo_empty ? 32'h0 : fifo_head;
    assign wr_fire  = MemWrEn & MemReady;
    assign pop      = wr_fire & ~fifo_empty;
    assign Done     = (state == ST_DONE);

    // ReqReady is registered, so it is computed from next-cycle values
    always_comb begin
        cnt_nxt  = fifo_count + CW'(push) - CW'(pop);
        last_nxt = last_seen | (accept & ReqLast);
        acc_nxt  = accepted + 32'(accept);
        ready_d  = ((state == ST_LOAD) & ~last_nxt
                    & (acc_nxt < 32'(MAX_WORDS))
                    & (32'(cnt_nxt) < DEPTH))
                 | ((state == ST_DONE) & Start);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_LOAD;
            last_seen <= 1'b0;
            accepted  <= '0;
            ready_q   <= 1'b0;
            MemAddr   <= BASE_ADDR;
            WordCount <= '0;
            Error     <= 1'b0;
`ifdef PAD_NOP_EN
            pad_cnt   <= '0;
`endif
        end else begin
            ready_q <= ready_d;
            if (wr_fire) begin
                MemAddr <= MemAddr + 32'd4;
                if (WordCount != 16'hFFFF) WordCount <= WordCount + 16'd1;
            end
            if (accept && !enc_ok) Error <= 1'b1;
            if (state == ST_LOAD && ReqValid && !last_seen
                && accepted == 32'(MAX_WORDS)) Error <= 1'b1;
            unique case (state)
                ST_LOAD: begin
                    accepted  <= acc_nxt;
                    last_seen <= last_nxt;
                    if (last_seen && fifo_empty) begin
`ifdef PAD_NOP_EN
                        pad_cnt <= '0;
                        state   <= (PAD_COUNT > 0) ? ST_PAD : ST_DONE;
`else
                        state <= ST_DONE;
`endif
                    end
                end
`ifdef PAD_NOP_EN
                ST_PAD: begin
                    if (wr_fire) begin
                        pad_cnt <= pad_cnt + 32'd1;
                        if (pad_cnt == 32'(PAD_COUNT - 1)) state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (Start) begin
                        state     <= ST_LOAD;
                        last_seen <= 1'b0;
                        accepted  <= '0;
                        MemAddr   <= BASE_ADDR;
                        WordCount <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encode table plus backpressure,
// illegal-op, word-limit, reset and optional padding sequences.
module tb_instr_encode_loader;
    import instr_encode_loader_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int MAXW = 20;
`ifdef PAD_NOP_EN
    localparam int PADN = 2;
`else
    localparam int PADN = 0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic [5:0]  ReqOp = '0;
    logic        ReqLast = 1'b0;
    logic [4:0]  ReqRs = '0, ReqRt = '0, ReqRd = '0, ReqShamt = '0;
    logic [15:0] ReqImm = '0;
    logic [25:0] ReqTarget = '0;
    logic        MemWrEn;
    logic        MemReady = 1'b0;
    logic [31:0] MemAddr, MemWData;
    logic [15:0] WordCount;
    logic        Done, Error;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    instr_encode_loader #(
        .BASE_ADDR (BASE),
        .DEPTH     (4),
        .MAX_WORDS (MAXW)
`ifdef PAD_NOP_EN
        ,
        .PAD_COUNT (PADN)
`endif
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqOp     (ReqOp),
        .ReqLast   (ReqLast),
        .ReqRs     (ReqRs),
        .ReqRt     (ReqRt),
        .ReqRd     (ReqRd),
        .ReqShamt  (ReqShamt),
        .ReqImm    (ReqImm),
        .ReqTarget (ReqTarget),
        .MemWrEn   (MemWrEn),
        .MemReady  (MemReady),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .WordCount (WordCount),
        .Done      (Done),
        .Error     (Error)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        Reset = 1'b0;
        ReqValid = 1'b0; ReqLast = 1'b0; Start = 1'b0; MemReady = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !ReqReady; i++) tick();
        chk("ready_wait", 32'(ReqReady), 32'd1);
    endtask

    // waits for Done; any write seen here must be a pad NOP
    task automatic wait_done(output int nwr);
        logic fire;
        nwr = 0;
        for (int c = 0; c < 50 && !Done; c++) begin
            fire = MemWrEn & MemReady;
            if (fire) chk("pad_word", MemWData, 32'h0);
            tick();
            if (fire) nwr++;
        end
        chk("done_wait", 32'(Done), 32'd1);
    endtask

    function automatic logic [31:0] addi_word(input int k);
        return {6'd8, 5'd0, 5'(k), 16'(16'h0100 + k)};
    endfunction

    task automatic drive_addi(input int k);
        ReqOp = OP_ADDI; ReqRs = 5'd0; ReqRt = 5'(k);
        ReqRd = 5'd0; ReqShamt = 5'd0; ReqImm = 16'(16'h0100 + k);
        ReqLast = (k == 4);
    endtask

    initial begin
        int nwr;
        int k;
        int wi;
        logic fire_req;
        logic fire_wr;
        logic mid_seen;

        vecs[0]  = '{OP_ADD,   5'd1,  5'd2,  5'd3,  5'd0, 16'h0,    26'h0,       32'h00221820};
        vecs[1]  = '{OP_ADDI,  5'd0,  5'd5,  5'd0,  5'd0, 16'hFFFF, 26'h0,       32'h2005FFFF};
        vecs[2]  = '{OP_LW,    5'd29, 5'd8,  5'd0,  5'd0, 16'h0004, 26'h0,       32'h8FA80004};
        vecs[3]  = '{OP_ROTR,  5'd7,  5'd2,  5'd4,  5'd3, 16'h0,    26'h0,       32'h002220C2};
        vecs[4]  = '{OP_ROTRV, 5'd3,  5'd2,  5'd4,  5'd9, 16'h0,    26'h0,       32'h00622046};
        vecs[5]  = '{OP_SLL,   5'd5,  5'd10, 5'd9,  5'd4, 16'h0,    26'h0,       32'h000A4900};
        vecs[6]  = '{OP_JR,    5'd31, 5'd3,  5'd3,  5'd0, 16'h0,    26'h0,       32'h03E00008};
        vecs[7]  = '{OP_CLZ,   5'd4,  5'd5,  5'd5,  5'd0, 16'h0,    26'h0,       32'h70852820};
        vecs[8]  = '{OP_BGTZ,  5'd6,  5'd9,  5'd0,  5'd0, 16'hFFFE, 26'h0,       32'h1CC0FFFE};
        vecs[9]  = '{OP_BGEZ,  5'd2,  5'd0,  5'd0,  5'd0, 16'h0010, 26'h0,       32'h04410010};
        vecs[10] = '{OP_SW,    5'd29, 5'd31, 5'd0,  5'd0, 16'h0008, 26'h0,       32'hAFBF0008};
        vecs[11] = '{OP_NOP,   5'd3,  5'd4,  5'd5,  5'd6, 16'h0007, 26'h8,       32'h00000000};
        vecs[12] = '{OP_J,     5'd0,  5'd0,  5'd0,  5'd0, 16'h0,    26'h3FFFFFF, 32'h0BFFFFFF};
        vecs[13] = '{OP_SUB,   5'd1,  5'd2,  5'd3,  5'd7, 16'h0,    26'h0,       32'h00221822};
        vecs[14] = '{OP_XORI,  5'd7,  5'd8,  5'd0,  5'd0, 16'hABCD, 26'h0,       32'h38E8ABCD};
        vecs[15] = '{OP_MOVZ,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0,    26'h0,       32'h0022180A};
        vecs[16] = '{OP_JAL,   5'd0,  5'd0,  5'd0,  5'd0, 16'h0,    26'h10,      32'h0C000010};

        // reset values while Reset is held low
        tick(); tick();
        chk("rst_ready", 32'(ReqReady), 32'd0);
        chk("rst_wren",  32'(MemWrEn), 32'd0);
        chk("rst_addr",  MemAddr, BASE);
        chk("rst_wdata", MemWData, 32'h0);
        chk("rst_count", 32'(WordCount), 32'd0);
        chk("rst_done",  32'(Done), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        Reset = 1'b1;
        MemReady = 1'b1;

        // table: one request at a time, write seen one cycle after accept
        for (int i = 0; i < NV; i++) begin
            wait_ready();
            ReqValid = 1'b1; ReqOp = vecs[i].op;
            ReqRs = vecs[i].rs; ReqRt = vecs[i].rt; ReqRd = vecs[i].rd;
            ReqShamt = vecs[i].sh; ReqImm = vecs[i].imm;
            ReqTarget = vecs[i].tgt; ReqLast = (i == NV - 1);
            tick();
            ReqValid = 1'b0; ReqLast = 1'b0;
            chk($sformatf("wren[%0d]", i), 32'(MemWrEn), 32'd1);
            chk($sformatf("word[%0d]", i), MemWData, vecs[i].exp);
            chk($sformatf("addr[%0d]", i), MemAddr, BASE + 32'(4 * i));
            tick();
        end
        wait_done(nwr);
        chk("tbl_padwr", 32'(nwr), 32'(PADN));
        chk("tbl_count", 32'(WordCount), 32'(NV + PADN));
        chk("tbl_addr",  MemAddr, BASE + 32'(4 * (NV + PADN)));
        chk("tbl_error", 32'(Error), 32'd0);
        chk("tbl_wren",  32'(MemWrEn), 32'd0);

        // Start re-arms
        Start = 1'b1; tick(); Start = 1'b0;
        chk("st_addr",  MemAddr, BASE);
        chk("st_count", 32'(WordCount), 32'd0);
        chk("st_done",  32'(Done), 32'd0);
        chk("st_ready", 32'(ReqReady), 32'd1);

        // backpressure: MemReady low 6 cycles while 5 requests offered
        MemReady = 1'b0;
        k = 0; wi = 0;
        ReqValid = 1'b1;
        drive_addi(0);
        for (int c = 0; c < 60 && !Done; c++) begin
            MemReady = (c >= 6);
            if (c >= 1 && c < 6) begin
                chk($sformatf("bp_wren[%0d]", c), 32'(MemWrEn), 32'd1);
                chk($sformatf("bp_word[%0d]", c), MemWData, addi_word(0));
                chk($sformatf("bp_addr[%0d]", c), MemAddr, BASE);
            end
            if (c == 5) begin
                chk("bp_accepted", 32'(k), 32'd4);
                chk("bp_ready",    32'(ReqReady), 32'd0);
            end
            fire_req = ReqValid & ReqReady;
            fire_wr  = MemWrEn & MemReady;
            if (fire_wr) begin
                chk($sformatf("bp_wword[%0d]", wi), MemWData,
                    (wi < 5) ? addi_word(wi) : 32'h0);
                chk($sformatf("bp_waddr[%0d]", wi), MemAddr,
                    BASE + 32'(4 * wi));
            end
            tick();
            if (fire_wr) wi++;
            if (fire_req) begin
                k++;
                if (k < 5) drive_addi(k);
                else begin
                    ReqValid = 1'b0; ReqLast = 1'b0;
                end
            end
        end
        chk("bp_done",   32'(Done), 32'd1);
        chk("bp_nreq",   32'(k), 32'd5);
        chk("bp_nwr",    32'(wi), 32'(5 + PADN));
        chk("bp_count",  32'(WordCount), 32'(5 + PADN));

        // illegal op marked last
        Start = 1'b1; tick(); Start = 1'b0;
        MemReady = 1'b1;
        ReqValid = 1'b1; ReqOp = 6'd40; ReqLast = 1'b1;
        tick();
        ReqValid = 1'b0; ReqLast = 1'b0;
        chk("ill_wren",  32'(MemWrEn), 32'd0);
        chk("ill_error", 32'(Error), 32'd1);
        wait_done(nwr);
        chk("ill_nwr",   32'(nwr), 32'(PADN));
        chk("ill_count", 32'(WordCount), 32'(PADN));
        Start = 1'b1; tick(); Start = 1'b0;
        chk("ill_st_addr",  MemAddr, BASE);
        chk("ill_st_count", 32'(WordCount), 32'd0);
        chk("ill_st_error", 32'(Error), 32'd1);

        // word limit: NOPs offered continuously past MAXW
        do_reset();
        MemReady = 1'b1;
        ReqValid = 1'b1; ReqOp = OP_NOP; ReqLast = 1'b0;
        k = 0; mid_seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (k == 8 && !mid_seen) begin
                chk("max_err_early", 32'(Error), 32'd0);
                mid_seen = 1'b1;
            end
            fire_req = ReqValid & ReqReady;
            tick();
            if (fire_req) k++;
        end
        chk("max_nreq",  32'(k), 32'(MAXW));
        chk("max_ready", 32'(ReqReady), 32'd0);
        chk("max_error", 32'(Error), 32'd1);
        chk("max_count", 32'(WordCount), 32'(MAXW));
        chk("max_done",  32'(Done), 32'd0);
        chk("max_wren",  32'(MemWrEn), 32'd0);
        ReqValid = 1'b0;

        // reset mid-program abandons buffered words
        do_reset();
        MemReady = 1'b0;
        ReqValid = 1'b1; ReqOp = OP_ADD;
        ReqRs = 5'd1; ReqRt = 5'd2; ReqRd = 5'd3; ReqLast = 1'b0;
        k = 0;
        for (int c = 0; c < 10 && k < 2; c++) begin
            fire_req = ReqValid & ReqReady;
            tick();
            if (fire_req) k++;
        end
        ReqValid = 1'b0;
        chk("mid_wren_pre", 32'(MemWrEn), 32'd1);
        #3;
        Reset = 1'b0;
        #1;
        chk("mid_wren",  32'(MemWrEn), 32'd0);
        chk("mid_ready", 32'(ReqReady), 32'd0);
        chk("mid_addr",  MemAddr, BASE);
        chk("mid_wdata", MemWData, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        MemReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mid_after_wren[%0d]", c), 32'(MemWrEn), 32'd0);
        end
        chk("mid_after_count", 32'(WordCount), 32'd0);

`ifdef PAD_NOP_EN
        // one ORI marked last, then two NOP pads
        do_reset();
        MemReady = 1'b1;
        wait_ready();
        ReqValid = 1'b1; ReqOp = OP_ORI; ReqRs = 5'd1; ReqRt = 5'd2;
        ReqImm = 16'h1234; ReqLast = 1'b1;
        tick();
        ReqValid = 1'b0; ReqLast = 1'b0;
        wi = 0;
        for (int c = 0; c < 20 && !Done; c++) begin
            fire_wr = MemWrEn & MemReady;
            if (fire_wr) begin
                chk($sformatf("pad_word[%0d]", wi), MemWData,
                    (wi == 0) ? 32'h34221234 : 32'h0);
                chk($sformatf("pad_addr[%0d]", wi), MemAddr,
                    BASE + 32'(4 * wi));
            end
            tick();
            if (fire_wr) wi++;
        end
        chk("pad_nwr",   32'(wi), 32'd3);
        chk("pad_count", 32'(WordCount), 32'd3);
        chk("pad_done",  32'(Done), 32'd1);
        #3;
        Reset = 1'b0;
        #1;
        chk("pad_rst_wren", 32'(MemWrEn), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
